// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word CLA sequencer: default slice width,
// sequencer state encoding and a word-slice extraction helper.
package cla_pkg;

    localparam int NBIT_DEF = 7;

    // Widest operand the slice helper handles (16 words of up to 16 bits).
    localparam int MAXW = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns word idx (nbit wide) of v, right-aligned and zero-extended.
    function automatic logic [MAXW-1:0] slice_of(input logic [MAXW-1:0] v,
                                                 input int idx,
                                                 input int nbit);
        logic [MAXW-1:0] mask;
        mask = (MAXW'(1) << nbit) - MAXW'(1);
        return (v >> (idx * nbit)) & mask;
    endfunction

endpackage

// File: rtl/gen_cla_decomposed.sv
// NBIT-bit carry-lookahead adder. Per-bit generate/propagate terms; every
// carry is formed directly from those terms rather than rippled.
module gen_cla_decomposed
    import cla_pkg::*;
#(
    parameter int NBIT = NBIT_DEF
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT:0]   s
);

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NBIT:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i] = OR over j<i of (g[j] & p[j+1..i-1]), plus cin & p[0..i-1]
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= NBIT; i++) begin
            term = cin;
            for (int j = 0; j < i; j++) term = term & p[j];
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign s = {c[NBIT], p ^ c[NBIT-1:0]};

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide adder built from one shared NBIT-bit CLA, stepped one word per clock
// LSW first, with the inter-word carry held in a register. Valid/ready on
// both sides; a retiring result and a new request may share one cycle.
module cla_multiword_seq
    import cla_pkg::*;
#(
    parameter int NBIT   = NBIT_DEF,
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NWORDS*NBIT-1:0] a_in,
    input  logic [NWORDS*NBIT-1:0] b_in,
    input  logic                   c_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NWORDS*NBIT-1:0] sum,
    output logic                   c_out,
    output logic                   busy
);

    localparam int W  = NWORDS * NBIT;
    localparam int CW = $clog2(NWORDS);

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg, b_reg;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;
    logic [NBIT-1:0] a_sl, b_sl;
    logic [NBIT:0]   s;

    assign last   = (cnt == CW'(NWORDS - 1));
    assign accept = in_valid && in_ready;

    // Word muxes feeding the shared adder
    always_comb begin
        a_sl = NBIT'(slice_of(MAXW'(a_reg), int'(cnt), NBIT));
        b_sl = NBIT'(slice_of(MAXW'(b_reg), int'(cnt), NBIT));
    end

    gen_cla_decomposed #(.NBIT(NBIT)) u_cla (
        .a   (a_sl),
        .b   (b_sl),
        .cin (carry),
        .s   (s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: DONE chains straight into RUN when a new request is waiting
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Operand capture, per-word sum write-back, carry and counter stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            for (int w = 0; w < NWORDS; w++)
                if (cnt == CW'(w)) sum[w*NBIT +: NBIT] <= s[NBIT-1:0];
            carry <= s[NBIT];
            if (last) begin
                c_out <= s[NBIT];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed and randomised checks of the multi-word CLA sequencer
// (NBIT=7, NWORDS=4, 28-bit operands).
module tb_cla_multiword_seq;

    localparam int NBIT   = 7;
    localparam int NWORDS = 4;
    localparam int W      = NBIT * NWORDS;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    cla_multiword_seq #(.NBIT(NBIT), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it until the accept edge; returns #1 after it
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int k;
        a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("send_timeout", 64'(k), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) check("done_timeout", 64'(lat), 64'(0));
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int cyc, first_acc, last_ret, nret, idx;
        logic acc, ret;
        logic [W-1:0] ba[3], bb[3], bs[3];
        logic         bc[3], bco[3];
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   ref_v;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(0));
        check("rst_c_out",     64'(c_out),     64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency check
        send(28'h0000001, 28'h0000002, 1'b0);
        check("basic_busy", 64'(busy), 64'(1));
        check("basic_in_ready_run", 64'(in_ready), 64'(0));
        wait_done(lat);
        check("basic_latency", 64'(lat), 64'(4));
        check("basic_sum",   64'(sum),   64'h0000003);
        check("basic_c_out", 64'(c_out), 64'(0));
        retire();
        check("basic_retire_ov", 64'(out_valid), 64'(0));
        check("basic_retire_ir", 64'(in_ready),  64'(1));

        // Carry crosses every word
        send(28'hFFFFFFF, 28'h0000000, 1'b1);
        wait_done(lat);
        check("ripple_sum",   64'(sum),   64'h0000000);
        check("ripple_c_out", 64'(c_out), 64'(1));
        retire();

        // Backpressure: result held, new operands on the bus ignored
        send(28'h1234567, 28'h0FEDCBA, 1'b0);
        wait_done(lat);
        a_in = 28'hFFFFFFF; b_in = 28'hFFFFFFF; c_in = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_sum",       64'(sum),       64'h2222221);
            check("bp_c_out",     64'(c_out),     64'(0));
            @(posedge clk);
            #1;
        end
        retire();

        // Back-to-back: each DONE cycle also accepts the next request
        ba[0] = 28'h0000010; bb[0] = 28'h0000020; bc[0] = 1'b0; bs[0] = 28'h0000030; bco[0] = 1'b0;
        ba[1] = 28'h7FFFFFF; bb[1] = 28'h8000001; bc[1] = 1'b0; bs[1] = 28'h0000000; bco[1] = 1'b1;
        ba[2] = 28'hABCDEF0; bb[2] = 28'h1111111; bc[2] = 1'b1; bs[2] = 28'hBCDF002; bco[2] = 1'b0;
        idx = 0; nret = 0; cyc = 0; first_acc = -1; last_ret = -1;
        a_in = ba[0]; b_in = bb[0]; c_in = bc[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (nret < 3 && cyc < 60) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            ret = out_valid;
            if (ret) begin
                check("b2b_sum",   64'(sum),   64'(bs[nret]));
                check("b2b_c_out", 64'(c_out), 64'(bco[nret]));
                nret++;
                last_ret = cyc;
            end
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge clk);
            cyc++;
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    a_in = ba[idx]; b_in = bb[idx]; c_in = bc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_count", 64'(nret), 64'(3));
        check("b2b_span",  64'(last_ret - first_acc), 64'(15));
        check("b2b_idle",  64'(in_ready), 64'(1));

        // Reset during the second RUN cycle
        send(28'h1234567, 28'h7654321, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sum",       64'(sum),       64'(0));
        check("mid_rst_c_out",     64'(c_out),     64'(0));
        check("mid_rst_busy",      64'(busy),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready",  64'(in_ready),  64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        send(28'h5555555, 28'h2AAAAAA, 1'b1);
        wait_done(lat);
        check("post_rst_latency", 64'(lat), 64'(4));
        check("post_rst_sum",     64'(sum),   64'h8000000);
        check("post_rst_c_out",   64'(c_out), 64'(0));
        retire();

        // Random operands with random consumer stalls
        for (int n = 0; n < 4000; n++) begin
            ra = W'($urandom) & MASK;
            rb = W'($urandom) & MASK;
            rc = 1'($urandom_range(0, 1));
            ref_v = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            send(ra, rb, rc);
            wait_done(lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            check("rand_result", 64'({c_out, sum}), 64'(ref_v));
            retire();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
